// File: rtl/cpu_multicycle_control.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/memory/writeback, drives datapath enables.
// Build option CPU_ILLEGAL_TRAP_EN: undefined opcodes enter a sticky TRAP state instead of executing as R-type.
module cpu_multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                stall,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic [1:0]          pcSource,
  output logic                iorD,
  output logic                memRead,
  output logic                memWrite,
  output logic                irWrite,
  output logic                regWrite,
  output logic                regDesination,
  output logic                memToReg,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          aluOP,
  output logic                jal,
  output logic                instr_done,
  output logic [STATE_W-1:0]  state,
  output logic                illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_TRAP   = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_XORI = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(9);

  state_t r_state;
  state_t w_next;

  logic w_is_mem, w_is_imm, w_is_jmp;
  logic w_pc_write, w_pc_write_cond, w_ir_write, w_reg_write, w_mem_write, w_done;

  assign w_is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign w_is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                    (opcode == OP_XORI) || (opcode == OP_SLTI);
  assign w_is_jmp = (opcode == OP_J) || (opcode == OP_JAL);

  always_comb begin
    w_next           = r_state;
    w_pc_write       = 1'b0;
    w_pc_write_cond  = 1'b0;
    w_ir_write       = 1'b0;
    w_reg_write      = 1'b0;
    w_mem_write      = 1'b0;
    w_done           = 1'b0;
    pcSource         = 2'b00;
    iorD             = 1'b0;
    memRead          = 1'b0;
    regDesination    = 1'b0;
    memToReg         = 1'b0;
    aluSrcA          = 1'b0;
    aluSrcB          = 2'b00;
    aluOP            = 2'b00;
    jal              = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead    = 1'b1;
        aluSrcB    = 2'b01;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        if (opcode == OP_R)        w_next = S_EXEC_R;
        else if (opcode == OP_BEQ) w_next = S_BRANCH;
        else if (w_is_mem)         w_next = S_MEMADR;
        else if (w_is_imm)         w_next = S_EXEC_I;
        else if (w_is_jmp)         w_next = S_JUMP;
        else begin
`ifdef CPU_ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_EXEC_R;
`endif
        end
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        memToReg    = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        iorD        = 1'b1;
        w_done      = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        aluSrcA = 1'b1;
        aluOP   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        aluOP   = (opcode == OP_ADDI) ? 2'b00 : 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        // ALU controls stay at their EXEC values so ALUOut feeds writeback unchanged
        w_reg_write   = 1'b1;
        w_done        = 1'b1;
        regDesination = (opcode != OP_ADDI);
        aluSrcB       = w_is_imm ? 2'b10 : 2'b00;
        aluOP         = (opcode == OP_ADDI) ? 2'b00 : 2'b10;
        w_next        = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA         = 1'b1;
        aluOP           = 2'b01;
        w_pc_write_cond = 1'b1;
        pcSource        = 2'b01;
        w_done          = 1'b1;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        pcSource   = 2'b10;
        jal        = (opcode == OP_JAL);
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
`ifdef CPU_ILLEGAL_TRAP_EN
      S_TRAP: w_next = S_TRAP;
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // stall suppresses every state-changing enable; memRead is left as-is so a request stays pending
  assign pcWrite     = w_pc_write      & ~stall;
  assign pcWriteCond = w_pc_write_cond & ~stall;
  assign irWrite     = w_ir_write      & ~stall;
  assign regWrite    = w_reg_write     & ~stall;
  assign memWrite    = w_mem_write     & ~stall;
  assign instr_done  = w_done          & ~stall;
  assign state       = STATE_W'(r_state);

  always_ff @(posedge clk) begin
    if (rst)         r_state <= S_FETCH;
    else if (!stall) r_state <= w_next;
  end

`ifdef CPU_ILLEGAL_TRAP_EN
  logic r_illegal_op;
  always_ff @(posedge clk) begin
    if (rst)                            r_illegal_op <= 1'b0;
    else if (!stall && w_next == S_TRAP) r_illegal_op <= 1'b1;
  end
  assign illegal_op = r_illegal_op;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// Directed self-checking bench for cpu_multicycle_control (default build or CPU_ILLEGAL_TRAP_EN).
module tb_cpu_multicycle_control;
  logic clk = 1'b0;
  logic rst = 1'b1, mem_ready = 1'b0, stall = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regWrite;
  logic regDesination, memToReg, aluSrcA, jal, instr_done, illegal_op;
  logic [1:0] pcSource, aluSrcB, aluOP;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass = 0;

  cpu_multicycle_control #(.OPCODE_W(6), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSource(pcSource), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite),
    .regDesination(regDesination), .memToReg(memToReg), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOP(aluOP), .jal(jal), .instr_done(instr_done),
    .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // {pcWrite,pcWriteCond,pcSource} {iorD,memRead,memWrite,irWrite}
  // {regWrite,regDesination,memToReg,aluSrcA} {aluSrcB,aluOP} {jal,instr_done}
  logic [17:0] ctrl;
  assign ctrl = {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite,
                 regWrite, regDesination, memToReg, aluSrcA, aluSrcB, aluOP, jal, instr_done};

  localparam logic [17:0] C_FETCH0  = 18'b0000_0100_0000_0100_00;
  localparam logic [17:0] C_FETCH1  = 18'b1000_0101_0000_0100_00;
  localparam logic [17:0] C_DECODE  = 18'b0000_0000_0000_1100_00;
  localparam logic [17:0] C_MEMADR  = 18'b0000_0000_0001_1000_00;
  localparam logic [17:0] C_MEMRD   = 18'b0000_1100_0000_0000_00;
  localparam logic [17:0] C_MEMWB   = 18'b0000_0000_1010_0000_01;
  localparam logic [17:0] C_MEMWR0  = 18'b0000_1010_0000_0000_00;
  localparam logic [17:0] C_MEMWR1  = 18'b0000_1010_0000_0000_01;
  localparam logic [17:0] C_EXECR   = 18'b0000_0000_0001_0010_00;
  localparam logic [17:0] C_EXECI_A = 18'b0000_0000_0001_1000_00;
  localparam logic [17:0] C_EXECI_L = 18'b0000_0000_0001_1010_00;
  localparam logic [17:0] C_WB_ADDI = 18'b0000_0000_1000_1000_01;
  localparam logic [17:0] C_WB_LOG  = 18'b0000_0000_1100_1010_01;
  localparam logic [17:0] C_WB_R    = 18'b0000_0000_1100_0010_01;
  localparam logic [17:0] C_BRANCH  = 18'b0101_0000_0001_0001_01;
  localparam logic [17:0] C_JAL     = 18'b1010_0000_0000_0000_11;
  localparam logic [17:0] C_J       = 18'b1010_0000_0000_0000_01;
  localparam logic [17:0] C_ZERO    = 18'b0;

  logic        seq_mr[16];
  logic        seq_sl[16];
  logic [3:0]  seq_st[16];
  logic [17:0] seq_ct[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cyc(input int i, input logic mr, input logic sl,
                         input logic [3:0] st, input logic [17:0] ct);
    seq_mr[i] = mr; seq_sl[i] = sl; seq_st[i] = st; seq_ct[i] = ct;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0) $display("FAIL reset_state got=%0d want=0", state);
    else n_pass++;
    n_checks++;
    if (ctrl !== C_FETCH0 || illegal_op !== 1'b0)
      $display("FAIL reset_outputs got=%b ill=%b want=%b ill=0", ctrl, illegal_op, C_FETCH0);
    else n_pass++;
  endtask

  task automatic test_lw();
    opcode = 6'b000010;
    set_cyc(0, 1, 0, 0, C_FETCH1); set_cyc(1, 1, 0, 1, C_DECODE);
    set_cyc(2, 1, 0, 2, C_MEMADR); set_cyc(3, 1, 0, 3, C_MEMRD);
    set_cyc(4, 1, 0, 4, C_MEMWB);
    for (int i = 0; i < 5; i++) begin
      mem_ready = seq_mr[i]; stall = seq_sl[i]; #1;
      n_checks++;
      if (state !== seq_st[i] || ctrl !== seq_ct[i])
        $display("FAIL lw_cyc%0d got state=%0d ctrl=%b want state=%0d ctrl=%b", i, state, ctrl, seq_st[i], seq_ct[i]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (state !== 4'd0) $display("FAIL lw_len got=%0d want=0", state);
    else n_pass++;
  endtask

  task automatic test_sw_wait();
    opcode = 6'b000011;
    set_cyc(0, 1, 0, 0, C_FETCH1); set_cyc(1, 1, 0, 1, C_DECODE);
    set_cyc(2, 1, 0, 2, C_MEMADR); set_cyc(3, 0, 0, 5, C_MEMWR0);
    set_cyc(4, 0, 0, 5, C_MEMWR0); set_cyc(5, 0, 0, 5, C_MEMWR0);
    set_cyc(6, 1, 0, 5, C_MEMWR1);
    for (int i = 0; i < 7; i++) begin
      mem_ready = seq_mr[i]; stall = seq_sl[i]; #1;
      n_checks++;
      if (state !== seq_st[i] || ctrl !== seq_ct[i])
        $display("FAIL sw_cyc%0d got state=%0d ctrl=%b want state=%0d ctrl=%b", i, state, ctrl, seq_st[i], seq_ct[i]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (state !== 4'd0) $display("FAIL sw_end got=%0d want=0", state);
    else n_pass++;
  endtask

  task automatic test_itype();
    logic [5:0]  ops[2];
    logic [17:0] ex[2];
    logic [17:0] wb[2];
    ops[0] = 6'b000100; ex[0] = C_EXECI_A; wb[0] = C_WB_ADDI;
    ops[1] = 6'b000110; ex[1] = C_EXECI_L; wb[1] = C_WB_LOG;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      set_cyc(0, 1, 0, 0, C_FETCH1); set_cyc(1, 1, 0, 1, C_DECODE);
      set_cyc(2, 1, 0, 7, ex[k]);    set_cyc(3, 1, 0, 8, wb[k]);
      for (int i = 0; i < 4; i++) begin
        mem_ready = seq_mr[i]; stall = seq_sl[i]; #1;
        n_checks++;
        if (state !== seq_st[i] || ctrl !== seq_ct[i])
          $display("FAIL itype%0d_cyc%0d got state=%0d ctrl=%b want state=%0d ctrl=%b", k, i, state, ctrl, seq_st[i], seq_ct[i]);
        else n_pass++;
        tick();
      end
    end
    n_checks++;
    if (state !== 4'd0) $display("FAIL itype_end got=%0d want=0", state);
    else n_pass++;
  endtask

  task automatic test_jump_branch();
    logic [5:0]  ops[3];
    logic [3:0]  st3[3];
    logic [17:0] c3[3];
    ops[0] = 6'b001001; st3[0] = 4'd10; c3[0] = C_JAL;
    ops[1] = 6'b001000; st3[1] = 4'd10; c3[1] = C_J;
    ops[2] = 6'b000001; st3[2] = 4'd9;  c3[2] = C_BRANCH;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      set_cyc(0, 1, 0, 0, C_FETCH1); set_cyc(1, 1, 0, 1, C_DECODE);
      set_cyc(2, 1, 0, st3[k], c3[k]);
      for (int i = 0; i < 3; i++) begin
        mem_ready = seq_mr[i]; stall = seq_sl[i]; #1;
        n_checks++;
        if (state !== seq_st[i] || ctrl !== seq_ct[i])
          $display("FAIL jmp%0d_cyc%0d got state=%0d ctrl=%b want state=%0d ctrl=%b", k, i, state, ctrl, seq_st[i], seq_ct[i]);
        else n_pass++;
        tick();
      end
      n_checks++;
      if (state !== 4'd0) $display("FAIL jmp%0d_end got=%0d want=0", k, state);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    // stall in FETCH with mem_ready high must not consume the access
    opcode = 6'b000000;
    set_cyc(0, 1, 1, 0, C_FETCH0); set_cyc(1, 1, 0, 0, C_FETCH1);
    set_cyc(2, 1, 0, 1, C_DECODE); set_cyc(3, 1, 1, 6, C_EXECR);
    set_cyc(4, 1, 1, 6, C_EXECR);  set_cyc(5, 1, 1, 6, C_EXECR);
    set_cyc(6, 1, 0, 6, C_EXECR);  set_cyc(7, 1, 0, 8, C_WB_R);
    for (int i = 0; i < 8; i++) begin
      mem_ready = seq_mr[i]; stall = seq_sl[i]; #1;
      n_checks++;
      if (state !== seq_st[i] || ctrl !== seq_ct[i])
        $display("FAIL stall_cyc%0d got state=%0d ctrl=%b want state=%0d ctrl=%b", i, state, ctrl, seq_st[i], seq_ct[i]);
      else n_pass++;
      tick();
    end
    stall = 1'b0;
  endtask

  task automatic test_undefined();
    opcode = 6'b111111; mem_ready = 1'b1; stall = 1'b0;
    tick(); tick();
`ifdef CPU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (state !== 4'd11 || ctrl !== C_ZERO || illegal_op !== 1'b1)
        $display("FAIL trap_cyc%0d got state=%0d ctrl=%b ill=%b want state=11 ctrl=0 ill=1", i, state, ctrl, illegal_op);
      else n_pass++;
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    n_checks++;
    if (state !== 4'd0 || illegal_op !== 1'b0)
      $display("FAIL trap_clear got state=%0d ill=%b want state=0 ill=0", state, illegal_op);
    else n_pass++;
`else
    n_checks++;
    if (state !== 4'd6 || ctrl !== C_EXECR)
      $display("FAIL undef_exec got state=%0d ctrl=%b want state=6 ctrl=%b", state, ctrl, C_EXECR);
    else n_pass++;
    tick();
    n_checks++;
    if (state !== 4'd8 || ctrl !== C_WB_R || illegal_op !== 1'b0)
      $display("FAIL undef_wb got state=%0d ctrl=%b ill=%b want state=8 ctrl=%b ill=0", state, ctrl, illegal_op, C_WB_R);
    else n_pass++;
    tick();
`endif
  endtask

  task automatic test_abort();
    // reset mid-LW, with stall also high, returns to FETCH without a retire
    opcode = 6'b000010; mem_ready = 1'b1; stall = 1'b0;
    tick(); tick();
    n_checks++;
    if (state !== 4'd2) $display("FAIL abort_pre got=%0d want=2", state);
    else n_pass++;
    rst = 1'b1; stall = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0; mem_ready = 1'b0; #1;
    n_checks++;
    if (state !== 4'd0 || instr_done !== 1'b0 || ctrl !== C_FETCH0)
      $display("FAIL abort_post got state=%0d ctrl=%b want state=0 ctrl=%b", state, ctrl, C_FETCH0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_itype();
    test_jump_branch();
    test_stall();
    test_undefined();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_multicycle_control.md
Name: cpu_multicycle_control

Overview:
- Multi-cycle control FSM for the CPU datapath. It sequences fetch, decode, execute, memory and writeback over several clocks, using the same opcode map and control-signal meanings as the single-cycle decoder.
- It drives register-file, ALU, PC and memory enables one state at a time.
- It waits on a memory-ready handshake and reports instruction retirement.

Parameters:
- OPCODE_W, 6, opcode field width.
- STATE_W, 4, width of the exported state register.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  6  IR[31:26]. Stable from DECODE until the next FETCH completes.
- mem_ready  in  1  memory access completes this cycle.
- stall  in  1  freeze FSM.
- pcWrite  out  1  unconditional PC load.
- pcWriteCond  out  1  PC load if ALU zero (BEQ).
- pcSource  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- iorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  out  1  memory read request.
- memWrite  out  1  memory write request.
- irWrite  out  1  instruction register load.
- regWrite  out  1  register-file write.
- regDesination  out  1  1 = rd, 0 = rt.
- memToReg  out  1  writeback source is memory data.
- aluSrcA  out  1  0 = PC, 1 = rs.
- aluSrcB  out  2  00 = rt, 01 = constant 1, 10 = sign-extended immediate, 11 = branch offset.
- aluOP  out  2  00 = add, 01 = sub, 10 = use funct/opcode.
- jal  out  1  write return address to link register.
- instr_done  out  1  one-cycle retire pulse.
- state  out  STATE_W  current state, for debug.
- illegal_op  out  1  sticky trap flag (only with the optional feature).

Behaviour:
- Reset: state = FETCH (0). All outputs are 0 on the cycle after rst, except the combinational FETCH outputs.
- Outputs are combinational from the state and the opcode (Moore/Mealy mix noted per state). Any output not listed for a state is 0.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JUMP 10, TRAP 11.
- FETCH:
  - Outputs: memRead = 1, iorD = 0, aluSrcA = 0, aluSrcB = 01, aluOP = 00, pcSource = 00.
  - irWrite and pcWrite equal mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Outputs: aluSrcA = 0, aluSrcB = 11, aluOP = 00.
  - Next state by opcode: 000000 -> EXEC_R; 000001 -> BRANCH; 000010/000011 -> MEMADR; 000100–000111 -> EXEC_I; 001000/001001 -> JUMP; others -> EXEC_R, or TRAP with the optional feature.
- MEMADR:
  - Outputs: aluSrcA = 1, aluSrcB = 10, aluOP = 00.
  - Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD:
  - Outputs: memRead = 1, iorD = 1.
  - Waits for mem_ready, then goes to MEMWB.
- MEMWB:
  - Outputs: regWrite = 1, memToReg = 1, regDesination = 0, instr_done = 1.
  - Next: FETCH.
- MEMWR:
  - Outputs: memWrite = 1, iorD = 1.
  - Waits for mem_ready. On the mem_ready cycle, instr_done = 1, then FETCH.
- EXEC_R:
  - Outputs: aluSrcA = 1, aluSrcB = 00, aluOP = 10.
  - Next: ALUWB.
- EXEC_I:
  - Outputs: aluSrcA = 1, aluSrcB = 10.
  - aluOP = 00 for ADDI, 10 for ANDI/XORI/SLTI.
  - Next: ALUWB.
- ALUWB:
  - Outputs: regWrite = 1, memToReg = 0, instr_done = 1.
  - regDesination = 1 for R-type/ANDI/XORI/SLTI, 0 for ADDI.
  - aluOP and aluSrcB are held at their EXEC values.
  - Next: FETCH.
- BRANCH:
  - Outputs: aluSrcA = 1, aluSrcB = 00, aluOP = 01, pcWriteCond = 1, pcSource = 01, instr_done = 1.
  - Next: FETCH.
- JUMP:
  - Outputs: pcWrite = 1, pcSource = 10, instr_done = 1; jal = 1 for opcode 001001 only.
  - Next: FETCH.
- Latency, assuming mem_ready arrives in 1 cycle:
  - LW: 5 cycles.
  - SW, R-type, I-type: 4 cycles.
  - BEQ, J, JAL: 3 cycles.
- stall:
  - The FSM holds its state.
  - pcWrite, pcWriteCond, irWrite, regWrite, memWrite and instr_done are forced to 0.
  - memRead is held, so a pending request stays asserted.
- If stall and mem_ready are high together, stall wins and the access is not consumed.
- rst has priority over stall. rst mid-instruction aborts it: no instr_done, state = FETCH next cycle.
- The state encoding never leaves 0–11. Any other value goes to FETCH on the next clock.

Optional Feature:
- Macro: CPU_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in DECODE goes to TRAP.
  - TRAP sets illegal_op = 1 (sticky) and holds all enables at 0.
  - The FSM stays in TRAP until rst; rst clears illegal_op.
- Undefined:
  - An undefined opcode is executed as R-type (EXEC_R -> ALUWB).
  - The TRAP state is absent, and illegal_op is tied to 0.

Test Plan:
- rst high 2 cycles, then low -> state = 0, memRead = 1, all write enables 0.
- opcode 000010, mem_ready high every cycle -> state sequence 0,1,2,3,4; in state 4, regWrite = 1, memToReg = 1, instr_done = 1; exactly 5 cycles.
- opcode 000011, mem_ready low 3 cycles while in MEMWR -> memWrite held 4 cycles; instr_done only on the mem_ready cycle; regWrite never 1.
- opcode 000100, then 000110 -> aluOP 00 then 10; regDesination 0 then 1 in ALUWB.
- opcode 001001 -> JUMP with pcWrite = 1, pcSource = 10, jal = 1. Then opcode 001000 -> jal = 0.
- opcode 111111 -> with CPU_ILLEGAL_TRAP_EN: state 11, illegal_op = 1 until rst. Without it: ALUWB reached and instr_done = 1. Also: stall asserted in EXEC_R for 3 cycles -> state frozen at 6, no enables asserted.
